// File: rtl/pt_stats_pkg.sv
// Shared display-mode encodings and width-generic saturating adder for the
// passthrough traffic statistics block.
package pt_stats_pkg;

    typedef enum logic [1:0] {
        MODE_FRAMES = 2'd0,
        MODE_BYTES  = 2'd1,
        MODE_ERRORS = 2'd2
    } mode_e;

    // Adds two values that are both known to fit in 'width' bits; the result
    // either clamps at all-ones or wraps modulo 2^width.
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input int unsigned width,
        input logic        sat
    );
        logic [32:0] sum;
        logic [32:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (33'd1 << width) - 33'd1;
        if (sat && (sum > lim)) begin
            return lim[31:0];
        end
        return sum[31:0] & lim[31:0];
    endfunction

endpackage

// File: rtl/pt_stats_chan.sv
// One monitored channel: frame, byte and error counters plus a sticky
// error flag, with synchronous clear taking priority over strobes.
module pt_stats_chan
    import pt_stats_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter bit          SAT   = 1'b1
) (
    input  logic             clk_50,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             frame_stb,
    input  logic [15:0]      frame_len,
    input  logic             err_stb,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_led
);

    logic [CNT_W-1:0] len_c;

    assign len_c = CNT_W'(frame_len);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
            err_cnt   <= '0;
            err_led   <= 1'b0;
        end else if (clear) begin
            frame_cnt <= '0;
            byte_cnt  <= '0;
            err_cnt   <= '0;
            err_led   <= 1'b0;
        end else begin
            if (frame_stb) begin
                frame_cnt <= CNT_W'(sat_add(32'(frame_cnt), 32'd1, CNT_W, SAT));
                byte_cnt  <= CNT_W'(sat_add(32'(byte_cnt), 32'(len_c), CNT_W, SAT));
            end
            if (err_stb) begin
                err_cnt <= CNT_W'(sat_add(32'(err_cnt), 32'd1, CNT_W, SAT));
                err_led <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pt_stats_mux.sv
// N-channel traffic statistics with manual or timed auto-scan channel
// selection and a holdable packed hex-digit display register.
module pt_stats_mux
    import pt_stats_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 50000000,
    parameter bit          SAT      = 1'b1,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk_50,
    input  logic                reset_n,
    input  logic                clear_i,
    input  logic [NUM_CH-1:0]   frame_stb_i,
    input  logic [NUM_CH*16-1:0] frame_len_i,
    input  logic [NUM_CH-1:0]   err_stb_i,
    input  logic [1:0]          mode_i,
    input  logic                auto_scan_i,
    input  logic [CH_W-1:0]     ch_sel_i,
    input  logic                hold_i,
    output logic [4*DIGITS-1:0] disp_o,
    output logic [CH_W-1:0]     disp_ch_o,
    output logic [NUM_CH-1:0]   err_led_o
);

    localparam int unsigned DW    = 4 * DIGITS;
    localparam int unsigned TMR_W = $clog2(SCAN_DIV);

    logic [CNT_W-1:0] frame_cnt [NUM_CH];
    logic [CNT_W-1:0] byte_cnt  [NUM_CH];
    logic [CNT_W-1:0] err_cnt   [NUM_CH];

    logic [TMR_W-1:0] timer;
    logic [CH_W-1:0]  idx;
    logic [CH_W-1:0]  sel_idx;
    logic [CH_W-1:0]  next_idx;
    logic [CH_W-1:0]  cur_idx;
    logic             auto_q;
    logic [CNT_W-1:0] sel_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        pt_stats_chan #(
            .CNT_W(CNT_W),
            .SAT  (SAT)
        ) u_chan (
            .clk_50   (clk_50),
            .reset_n  (reset_n),
            .clear    (clear_i),
            .frame_stb(frame_stb_i[g]),
            .frame_len(frame_len_i[16*g +: 16]),
            .err_stb  (err_stb_i[g]),
            .frame_cnt(frame_cnt[g]),
            .byte_cnt (byte_cnt[g]),
            .err_cnt  (err_cnt[g]),
            .err_led  (err_led_o[g])
        );
    end

    assign sel_idx  = (32'(ch_sel_i) >= NUM_CH) ? '0 : ch_sel_i;
    assign next_idx = (32'(idx) == NUM_CH - 1) ? '0 : idx + CH_W'(1);
    // Manual selection bypasses the index register so the display follows
    // ch_sel_i one cycle after it changes.
    assign cur_idx  = auto_scan_i ? idx : sel_idx;

    always_comb begin
        sel_cnt = frame_cnt[cur_idx];
        case (mode_e'(mode_i))
            MODE_BYTES:  sel_cnt = byte_cnt[cur_idx];
            MODE_ERRORS: sel_cnt = err_cnt[cur_idx];
            default:     sel_cnt = frame_cnt[cur_idx];
        endcase
    end

    // auto_q resets high so leaving reset already in auto mode keeps the
    // reset-loaded timer rather than reloading it a second time.
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            timer  <= TMR_W'(SCAN_DIV - 1);
            idx    <= '0;
            auto_q <= 1'b1;
        end else begin
            auto_q <= auto_scan_i;
            if ((auto_scan_i && !auto_q) || (timer == '0)) begin
                timer <= TMR_W'(SCAN_DIV - 1);
            end else begin
                timer <= timer - TMR_W'(1);
            end
            if (!auto_scan_i) begin
                idx <= sel_idx;
            end else if (auto_q && (timer == '0)) begin
                idx <= next_idx;
            end
        end
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            disp_o    <= '0;
            disp_ch_o <= '0;
        end else if (!hold_i) begin
            disp_o    <= DW'(sel_cnt);
            disp_ch_o <= cur_idx;
        end
    end

endmodule

// File: doc/pt_stats_mux.md
# pt_stats_mux

Parametrised per-channel traffic statistics block for the GigE passthrough target, generalising the fixed two-channel frame/nibble counters into N channels with frame, byte and error counters. It adds saturating or wrapping arithmetic, synchronous clear, sticky error flags, a display freeze, and manual or timed auto-scan channel selection. It sits in the clk_50 domain behind the per-PHY passthrough paths. Its packed hex-digit output feeds the existing io_seg7 decoders on HEX0..HEX7.

## Interface
- NUM_CH, 2, number of monitored channels (1..8)
- CNT_W, 16, width of every counter (8..32)
- DIGITS, 8, number of hex digits driven on disp_o
- SCAN_DIV, 50000000, clk_50 cycles per auto-scan step (≥2)
- SAT, 1, 1 = counters saturate at all-ones, 0 = counters wrap

Ports:
- clk_50  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- clear_i  in  1  synchronous clear of all counters and sticky flags
- frame_stb_i  in  NUM_CH  one-cycle end-of-frame pulse per channel
- frame_len_i  in  NUM_CH*16  frame byte length; slice ch = [16ch+15:16ch]; valid only with frame_stb_i[ch]
- err_stb_i  in  NUM_CH  one-cycle frame-error pulse per channel (rx_er or FIFO full)
- mode_i  in  2  display select: 0 frames, 1 bytes, 2 errors, 3 treated as 0
- auto_scan_i  in  1  1 = rotate channels every SCAN_DIV cycles, 0 = use ch_sel_i
- ch_sel_i  in  clog2(NUM_CH) (min 1)  manual channel select
- hold_i  in  1  freeze disp_o and disp_ch_o
- disp_o  out  4*DIGITS  packed nibbles, digit 0 in [3:0]
- disp_ch_o  out  clog2(NUM_CH) (min 1)  channel currently displayed
- err_led_o  out  NUM_CH  sticky per-channel error flag

## Operation
- Per channel: frame_cnt, byte_cnt and err_cnt, each CNT_W bits.
- frame_stb_i[ch]: frame_cnt += 1 and byte_cnt += frame_len (zero-extended or truncated to CNT_W).
- err_stb_i[ch]: err_cnt += 1 and err_led_o[ch] is set. err_stb_i and frame_stb_i in the same cycle both apply.
- SAT=1: any sum that overflows CNT_W yields all-ones and stays there. SAT=0: modulo 2^CNT_W.
- clear_i zeroes all counters and err_led_o. Clear wins over strobes in the same cycle, so those strobes are lost. Clear does not reset the scan timer or the channel index.
- Channel index, auto mode: a down-counter loads SCAN_DIV-1 and decrements. At 0 it reloads, and the index advances by 1, wrapping from NUM_CH-1 to 0.
- Channel index, manual mode: index = ch_sel_i. Values ≥ NUM_CH select channel 0.
- Switching auto_scan_i 0→1 reloads the timer and keeps the current index.
- Display register: each cycle, unless hold_i, disp_o takes the mode_i counter of the indexed channel and disp_ch_o takes the index. The value is zero-extended or truncated to 4*DIGITS. The timer keeps running during hold_i.

## Timing
- Reset (reset_n low, asynchronous): all counters 0, err_led_o 0, disp_o 0, disp_ch_o 0, channel index 0, timer SCAN_DIV-1.
- Strobe at edge t → counter updated at t+1 → visible on disp_o at t+2.
- err_stb_i at t → err_led_o high after t+1.
- mode_i or ch_sel_i change at t → disp_o reflects it at t+1.
- clear_i at t → counters 0 at t+1, disp_o 0 at t+2 unless hold_i.
- Auto scan: index changes exactly every SCAN_DIV cycles; disp_ch_o follows one cycle later.
- Strobes are single-cycle pulses already synchronised into clk_50. Back-to-back strobes on consecutive cycles must each be counted.

## Structure
- Shared package pt_stats_pkg holds the MODE_FRAMES=0, MODE_BYTES=1 and MODE_ERRORS=2 constants and a saturating-add function parametrised by width.
- Sub-module pt_stats_chan holds one channel's three counters and its sticky flag, parametrised by CNT_W and SAT. It is instantiated NUM_CH times via generate.
- The top holds the scan timer, index logic and display register.

## Test plan
- Reset mid-count: assert reset_n low asynchronously between edges → all outputs 0 immediately; timer reloads to SCAN_DIV-1.
- Counting: NUM_CH=2, mode 1, three frame_stb_i[1] pulses with lengths 64, 1500, 1518 → byte_cnt 3082 (0x0C0A) on disp_o two cycles after the last strobe; mode 0 → 3.
- Saturation: CNT_W=8, SAT=1, 300 frame strobes → 0xFF. Same with SAT=0 → 0x2C (300 mod 256).
- Clear collision: clear_i coincident with frame_stb_i[0] and err_stb_i[0] → frame_cnt 0, err_cnt 0, err_led_o[0] 0.
- Auto scan: SCAN_DIV=4, NUM_CH=3, auto_scan_i=1 → disp_ch_o sequence 0,1,2,0 in steps of 4 cycles. Hold_i asserted for 10 cycles → disp_o and disp_ch_o frozen while the index keeps advancing.
- Manual select: ch_sel_i=3 with NUM_CH=3 → disp_ch_o 0. err_stb_i[2] once → err_led_o 3'b100 stays set until clear_i.
